g_and_input_debounce: RTL and testbench
=======================================

# g_and_input_debounce

Three-channel input conditioner that sits directly upstream of the 3-input AND gate stage. It takes raw, asynchronous switch/button levels, synchronises each into the clock domain, and debounces each channel independently. It drives clean, glitch-free levels A, B, C straight into the AND gate's A/B/C inputs, plus one-cycle edge pulses for downstream counters or LEDs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 100000 (1 ms at 100 MHz). Number of consecutive cycles a synchronised input must differ from the current output before the output flips. Legal range ≥ 2.
- SYNC_STAGES, default 2. Synchroniser depth per channel. Legal range ≥ 2.

Ports:
- clk  input  1  Single system clock; all state is on its rising edge.
- rst_n  input  1  Reset; asynchronous assert, active-low. Release is synchronous to clk.
- sw_in  input  3  Raw asynchronous inputs. Bit 0 maps to A, bit 1 to B, bit 2 to C.
- A  output  1  Debounced level of sw_in[0]. Feeds AND-gate input A.
- B  output  1  Debounced level of sw_in[1]. Feeds AND-gate input B.
- C  output  1  Debounced level of sw_in[2]. Feeds AND-gate input C.
- rise  output  3  One-cycle pulse when the corresponding debounced output goes 0→1.
- fall  output  3  One-cycle pulse when the corresponding debounced output goes 1→0.

## Operation
- Channels are fully independent; there are no cross-channel interactions.
- Per channel, the state is:
  - a SYNC_STAGES-deep flop chain producing `s`;
  - the debounced level `db` (drives A/B/C);
  - a counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
- Each edge, per channel:
  - If s == db: cnt ← 0, no pulse.
  - If s != db and cnt < DEBOUNCE_CYCLES−1: cnt ← cnt+1.
  - If s != db and cnt == DEBOUNCE_CYCLES−1: db ← s, cnt ← 0. Assert rise (if s=1) or fall (if s=0) for exactly this one cycle.
- Any return of s to db before terminal count discards progress: cnt restarts from 0 on the next mismatch. Bounce shorter than DEBOUNCE_CYCLES therefore never reaches the outputs.
- rise and fall are registered and asserted in the same cycle that A/B/C changes. For a given bit, rise and fall are never both 1.
- The counter saturates logically at the terminal value; it never wraps, because it clears on the flip.

## Timing
- Reset (rst_n=0, asynchronous) sets:
  - all sync flops, db, and cnt to 0;
  - A=B=C=0, rise=fall=3'b000.
- Reset mid-count discards all progress. After release, an input held at 1 requires the full latency again.
- Latency: count the edge that first samples a new raw level as edge 1. The output changes on edge SYNC_STAGES + DEBOUNCE_CYCLES, so the new value is visible after that edge.
  - With defaults and DEBOUNCE_CYCLES=4, that is edge 6.
- The input must be held stable from its first sample through that edge. A single mismatch-free cycle restarts the count.
- An input already equal to the output produces no activity at all.
- If all three channels change simultaneously, they flip on the same edge, and the AND-gate output sees a single clean transition.

## Structure
- The shared package/include holds:
  - DEFAULT_DEBOUNCE_CYCLES (100000);
  - DEFAULT_SYNC_STAGES (2);
  - the counter-width expression, so the sim bench and top-level use identical defaults.
- Natural sub-module: `debounce_ch`. It is one channel with ports clk, rst_n, raw, level, rise, fall, and the same two parameters.
  - The top instantiates it 3× (generate loop or explicit) and maps level[0..2] to A/B/C.

## Test plan
Run with DEBOUNCE_CYCLES=4 and SYNC_STAGES=2 unless noted.
- **Reset values:** hold rst_n=0 with sw_in=3'b111 → A=B=C=0 and rise=fall=0 throughout. Release, keep sw_in=3'b111 → A/B/C rise on edge 6 after release, with rise=3'b111 for exactly one cycle.
- **Glitch rejection:** 0→1 pulse on sw_in[1] lasting 3 cycles → B stays 0 and rise[1] never asserts. A 4-cycle pulse (sampled 4 edges) → B goes to 1.
- **Bounce restart:** sw_in[0] toggles 1,0,1,0,1 at 1-cycle spacing, then holds 1 → A goes high exactly 6 edges after the final 0→1 sample.
- **Falling edge:** with A=1 settled, drive sw_in[0]=0 and hold → A=0 on edge 6, fall[0]=1 for one cycle, rise[0]=0.
- **Independence and AND path:** stagger sw_in[2:0] changes by 2 cycles each → each output flips 6 edges after its own change. The downstream AND of A&B&C goes high exactly once, on the last flip.
- **Asynchronous reset mid-count:** assert rst_n=0 between clock edges while cnt=2 → outputs clear immediately without waiting for a clock edge. After release, the full 6-edge latency applies again.

Source files
------------

// File: rtl/g_and_input_debounce_pkg.sv
// Shared defaults and helpers for the three-channel AND-gate input conditioner.
// The bench and the top take their default parameter values from here.
package g_and_input_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int NUM_CHANNELS            = 3;

    // Counter width wide enough to hold DEBOUNCE_CYCLES-1, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    // Edge event registered alongside the debounced level.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

endpackage

// File: rtl/g_and_input_debounce_debounce_ch.sv
// One debounce channel: synchroniser chain, mismatch counter, debounced level,
// and registered one-cycle rise/fall pulses coincident with the level change.
module debounce_ch
    import g_and_input_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   db_q;
    logic                   db_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    edge_e                  edge_q;
    edge_e                  edge_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Any cycle where s agrees with the output throws away accumulated progress.
    always_comb begin
        db_d   = db_q;
        cnt_d  = '0;
        edge_d = EDGE_NONE;
        if (s != db_q) begin
            if (cnt_q == TERMINAL) begin
                db_d   = s;
                edge_d = s ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
            edge_q <= EDGE_NONE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
        end
    end

    assign level = db_q;
    assign rise  = (edge_q == EDGE_RISE);
    assign fall  = (edge_q == EDGE_FALL);

endmodule

// File: rtl/g_and_input_debounce.sv
// Three independent debounce channels feeding the A/B/C inputs of the AND stage,
// with per-channel one-cycle rise/fall pulses.
module g_and_input_debounce
    import g_and_input_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] sw_in,
    output logic                    A,
    output logic                    B,
    output logic                    C,
    output logic [NUM_CHANNELS-1:0] rise,
    output logic [NUM_CHANNELS-1:0] fall
);

    logic [NUM_CHANNELS-1:0] level_w;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_ch (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (sw_in[gi]),
                .level(level_w[gi]),
                .rise (rise[gi]),
                .fall (fall[gi])
            );
        end
    endgenerate

    assign A = level_w[0];
    assign B = level_w[1];
    assign C = level_w[2];

endmodule

// File: tb/tb_g_and_input_debounce.sv
// Directed bench for g_and_input_debounce: stimulus pushes expected edge events
// into a queue, a negedge monitor pops and compares whenever a pulse appears.
module tb_g_and_input_debounce;

    localparam int DB  = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + DB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw_in = 3'b111;
    logic       A, B, C;
    logic [2:0] rise, fall;

    always #5 clk = ~clk;

    g_and_input_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw_in(sw_in),
        .A    (A),
        .B    (B),
        .C    (C),
        .rise (rise),
        .fall (fall)
    );

    typedef struct {
        int unsigned edge_no;
        logic [2:0]  lvl;
        logic [2:0]  rise;
        logic [2:0]  fall;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_cnt  = 0;
    int          n_assert  = 0;
    int          n_fail    = 0;
    int          and_rises = 0;
    logic [2:0]  prev_lvl  = 3'b000;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic push(input int unsigned dly, input logic [2:0] lvl,
                        input logic [2:0] r, input logic [2:0] f);
        exp_t e;
        e.edge_no = edge_cnt + dly;
        e.lvl     = lvl;
        e.rise    = r;
        e.fall    = f;
        exp_q.push_back(e);
    endtask

    // Monitor: pulses must match the queue head; levels may only move with a pulse.
    always @(negedge clk) begin
        logic [2:0] lvl;
        exp_t       e;
        lvl = {C, B, A};
        if (!rst_n) begin
            prev_lvl = 3'b000;
        end else begin
            if (rise != 3'b000 || fall != 3'b000) begin
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: edge=%0d lvl=%b rise=%b fall=%b, expected no pulse",
                             edge_cnt, lvl, rise, fall);
                end else begin
                    e = exp_q.pop_front();
                    if (edge_cnt != e.edge_no || lvl !== e.lvl || rise !== e.rise || fall !== e.fall) begin
                        n_fail++;
                        $display("FAIL txn: got edge=%0d lvl=%b rise=%b fall=%b, expected edge=%0d lvl=%b rise=%b fall=%b",
                                 edge_cnt, lvl, rise, fall, e.edge_no, e.lvl, e.rise, e.fall);
                    end else begin
                        $display("txn ok: edge=%0d lvl=%b rise=%b fall=%b", edge_cnt, lvl, rise, fall);
                    end
                end
            end else begin
                chk("level_hold", {29'd0, lvl}, {29'd0, prev_lvl});
            end
            if (lvl == 3'b111 && prev_lvl != 3'b111) and_rises++;
            prev_lvl = lvl;
        end
    end

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held with inputs high: nothing may propagate.
        rst_n = 1'b0;
        sw_in = 3'b111;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("rst_lvl",  {29'd0, C, B, A}, 32'd0);
            chk("rst_rise", {29'd0, rise},    32'd0);
            chk("rst_fall", {29'd0, fall},    32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(LAT, 3'b111, 3'b111, 3'b000);
        drain(20);
        idle(4);

        // Falling edge on A only.
        @(negedge clk);
        sw_in = 3'b110;
        push(LAT, 3'b110, 3'b000, 3'b001);
        drain(20);
        idle(4);

        // Bring B low to prepare the glitch tests.
        @(negedge clk);
        sw_in = 3'b100;
        push(LAT, 3'b100, 3'b000, 3'b010);
        drain(20);
        idle(4);

        // 3-cycle pulse on B is rejected.
        @(negedge clk);
        sw_in = 3'b110;
        idle(3);
        sw_in = 3'b100;
        idle(12);

        // 4-cycle pulse on B passes, then B falls back after the full latency.
        @(negedge clk);
        sw_in = 3'b110;
        push(LAT, 3'b110, 3'b010, 3'b000);
        idle(4);
        sw_in = 3'b100;
        push(LAT, 3'b100, 3'b000, 3'b010);
        drain(30);
        idle(4);

        // Bounce on A: 1,0,1,0,1 then hold 1.
        @(negedge clk); sw_in = 3'b101;
        @(negedge clk); sw_in = 3'b100;
        @(negedge clk); sw_in = 3'b101;
        @(negedge clk); sw_in = 3'b100;
        @(negedge clk); sw_in = 3'b101;
        push(LAT, 3'b101, 3'b001, 3'b000);
        drain(20);
        idle(4);

        // Simultaneous fall on A and C.
        @(negedge clk);
        sw_in = 3'b000;
        push(LAT, 3'b000, 3'b000, 3'b101);
        drain(20);
        idle(4);

        // Staggered rises; the AND of A&B&C must go high exactly once.
        and_rises = 0;
        @(negedge clk);
        sw_in = 3'b001;
        push(LAT, 3'b001, 3'b001, 3'b000);
        idle(2);
        sw_in = 3'b011;
        push(LAT, 3'b011, 3'b010, 3'b000);
        idle(2);
        sw_in = 3'b111;
        push(LAT, 3'b111, 3'b100, 3'b000);
        drain(30);
        idle(4);
        chk("and_once", and_rises, 1);

        // Asynchronous reset mid-count (cnt=2), cleared without a clock edge.
        @(negedge clk);
        sw_in = 3'b000;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_lvl",  {29'd0, C, B, A}, 32'd0);
        chk("async_rst_rise", {29'd0, rise},    32'd0);
        chk("async_rst_fall", {29'd0, fall},    32'd0);
        sw_in = 3'b111;
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        push(LAT, 3'b111, 3'b111, 3'b000);
        drain(20);
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
